wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter_pkg.sv | 18 +
 rtl/wb_mem_arbiter_if.sv | 17 +
 rtl/arb_watchdog.sv | 36 +++
 rtl/wb_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_mem_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared encodings for the instruction/data Wishbone memory arbiter.
package wb_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnerNone = 2'b00,
    OwnerI    = 2'b01,
    OwnerD    = 2'b10
  } owner_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// One Wishbone classic link; master drives the request, slave drives the response.
interface wb_mem_arbiter_if #(
  parameter int unsigned AW = 32
);
  logic [AW-1:0] addr;
  logic [AW-1:0] wdat;
  logic [AW-1:0] rdat;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic          ack;
  logic          err;

  modport master (output addr, wdat, sel, we, cyc, stb, input rdat, ack, err);
  modport slave  (input addr, wdat, sel, we, cyc, stb, output rdat, ack, err);
endinterface

// File: rtl/arb_watchdog.sv
// Counts granted strobe cycles with no slave response and flags an abort at the limit.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic tick_i,
  input  logic resp_i,
  output logic abort_o
);
  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  // Idle cycles hold the count at zero, so every new grant starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || resp_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign abort_o = active_i && (cnt_q == Limit);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one shared memory slave with a response watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise data has fixed priority.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned AW      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_mem_arbiter_if.slave  i_bus,
  wb_mem_arbiter_if.slave  d_bus,
  wb_mem_arbiter_if.master s_bus,
  output logic [1:0]       owner_o
);
  state_e        state_q, state_d;
  owner_e        owner;
  logic          req_i, req_d;
  logic          data_wins;
  logic          owner_stb, resp, abort;
  logic [AW-1:0] d_wdat;
  logic          unused_i_wr;

  assign req_i = i_bus.cyc & i_bus.stb;
  assign req_d = d_bus.cyc & d_bus.stb;

  // The fetch port is read-only; its write fields are never forwarded.
  assign unused_i_wr = ^{i_bus.we, i_bus.wdat};
  assign d_wdat      = d_bus.we ? d_bus.wdat : '0;

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_d_q, prio_d_d;  // 1: data master wins the next contention

  always_comb begin
    prio_d_d = prio_d_q;
    if (state_q == StIdle && state_d == StGntI) begin
      prio_d_d = 1'b1;
    end else if (state_q == StIdle && state_d == StGntD) begin
      prio_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_d_q <= 1'b1;
    end else begin
      prio_d_q <= prio_d_d;
    end
  end

  assign data_wins = prio_d_q;
`else
  assign data_wins = 1'b1;
`endif

  assign owner_stb = ((state_q == StGntI) & i_bus.stb) | ((state_q == StGntD) & d_bus.stb);
  assign resp      = s_bus.ack | s_bus.err;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_arb_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active_i(state_q != StIdle),
    .tick_i  (owner_stb),
    .resp_i  (resp),
    .abort_o (abort)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_d && (data_wins || !req_i)) begin
          state_d = StGntD;
        end else if (req_i) begin
          state_d = StGntI;
        end
      end
      StGntI: if (abort || !i_bus.cyc) state_d = StIdle;
      StGntD: if (abort || !d_bus.cyc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request path follows the owner; err beats ack, and an abort forces err and drops cyc/stb.
  always_comb begin
    owner      = OwnerNone;
    s_bus.addr = '0;
    s_bus.wdat = '0;
    s_bus.sel  = '0;
    s_bus.we   = 1'b0;
    s_bus.cyc  = 1'b0;
    s_bus.stb  = 1'b0;
    i_bus.rdat = '0;
    i_bus.ack  = 1'b0;
    i_bus.err  = 1'b0;
    d_bus.rdat = '0;
    d_bus.ack  = 1'b0;
    d_bus.err  = 1'b0;
    unique case (state_q)
      StGntI: begin
        owner      = OwnerI;
        s_bus.addr = i_bus.addr;
        s_bus.sel  = i_bus.sel;
        s_bus.cyc  = i_bus.cyc & ~abort;
        s_bus.stb  = i_bus.stb & ~abort;
        i_bus.rdat = s_bus.rdat;
        i_bus.ack  = s_bus.ack & ~s_bus.err & ~abort;
        i_bus.err  = s_bus.err | abort;
      end
      StGntD: begin
        owner      = OwnerD;
        s_bus.addr = d_bus.addr;
        s_bus.wdat = d_wdat;
        s_bus.sel  = d_bus.sel;
        s_bus.we   = d_bus.we;
        s_bus.cyc  = d_bus.cyc & ~abort;
        s_bus.stb  = d_bus.stb & ~abort;
        d_bus.rdat = s_bus.rdat;
        d_bus.ack  = s_bus.ack & ~s_bus.err & ~abort;
        d_bus.err  = s_bus.err | abort;
      end
      default: ;
    endcase
  end

  assign owner_o = owner;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed, table-driven bench for wb_mem_arbiter with TIMEOUT=4.
module tb_wb_mem_arbiter;

  localparam logic [31:0] IAddr = 32'h0000_0100;
  localparam logic [31:0] DAddr = 32'h0000_0200;
  localparam logic [31:0] DWdat = 32'hCAFE_0001;
  localparam logic [31:0] SRdat = 32'h0000_0013;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] owner;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.AW(32)) i_bus ();
  wb_mem_arbiter_if #(.AW(32)) d_bus ();
  wb_mem_arbiter_if #(.AW(32)) s_bus ();

  wb_mem_arbiter #(
    .TIMEOUT(4),
    .AW     (32)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .i_bus  (i_bus),
    .d_bus  (d_bus),
    .s_bus  (s_bus),
    .owner_o(owner)
  );

  typedef struct {
    string      name;
    logic       i_req, d_req, d_we, ack, err;
    logic [1:0] e_owner;
    logic       e_cyc, e_we, e_iack, e_ierr, e_dack, e_derr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic ir, logic dr, logic dw, logic a, logic e,
                              logic [1:0] eo, logic ec, logic ew, logic ia, logic ie,
                              logic da, logic de);
    vec_t v;
    v.name = n; v.i_req = ir; v.d_req = dr; v.d_we = dw; v.ack = a; v.err = e;
    v.e_owner = eo; v.e_cyc = ec; v.e_we = ew;
    v.e_iack = ia; v.e_ierr = ie; v.e_dack = da; v.e_derr = de;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and let outputs settle.
  task automatic cycle(logic ir, logic dr, logic dw, logic a, logic e);
    @(negedge clk);
    i_bus.cyc = ir; i_bus.stb = ir;
    d_bus.cyc = dr; d_bus.stb = dr; d_bus.we = dw;
    s_bus.ack = a;  s_bus.err = e;
    #2;
  endtask

  task automatic chk_all(string n, logic [1:0] eo, logic ec, logic ew, logic ia, logic ie,
                         logic da, logic de, logic dw);
    logic [31:0] e_addr, e_sdat, e_idat, e_ddat;
    e_addr = (eo == 2'b01) ? IAddr : (eo == 2'b10) ? DAddr : 32'h0;
    e_sdat = (eo == 2'b10 && dw) ? DWdat : 32'h0;
    e_idat = (eo == 2'b01) ? SRdat : 32'h0;
    e_ddat = (eo == 2'b10) ? SRdat : 32'h0;
    chk({n, ".owner"}, 32'(owner), 32'(eo));
    chk({n, ".s_cyc"}, 32'(s_bus.cyc), 32'(ec));
    chk({n, ".s_stb"}, 32'(s_bus.stb), 32'(ec));
    chk({n, ".s_we"}, 32'(s_bus.we), 32'(ew));
    chk({n, ".s_addr"}, s_bus.addr, e_addr);
    chk({n, ".s_dat"}, s_bus.wdat, e_sdat);
    chk({n, ".i_ack"}, 32'(i_bus.ack), 32'(ia));
    chk({n, ".i_err"}, 32'(i_bus.err), 32'(ie));
    chk({n, ".i_dat"}, i_bus.rdat, e_idat);
    chk({n, ".d_ack"}, 32'(d_bus.ack), 32'(da));
    chk({n, ".d_err"}, 32'(d_bus.err), 32'(de));
    chk({n, ".d_dat"}, d_bus.rdat, e_ddat);
  endtask

  initial begin
    logic [1:0] rr_owner;
`ifdef ARB_ROUND_ROBIN_EN
    rr_owner = 2'b01;
`else
    rr_owner = 2'b10;
`endif
    i_bus.addr = IAddr; i_bus.sel = 4'hF; i_bus.we = 1'b0; i_bus.wdat = '0;
    i_bus.cyc = 1'b0;   i_bus.stb = 1'b0;
    d_bus.addr = DAddr; d_bus.sel = 4'h3; d_bus.we = 1'b0; d_bus.wdat = DWdat;
    d_bus.cyc = 1'b0;   d_bus.stb = 1'b0;
    s_bus.rdat = SRdat; s_bus.ack = 1'b0; s_bus.err = 1'b0;

    //                  name                 ir dr dw a  e   own  cyc we ia ie da de
    vecs.push_back(mk("v00_reset_idle",     0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v01_fetch_req",      1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v02_fetch_gnt",      1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v03_fetch_wait",     1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v04_fetch_ack",      1, 0, 0, 1, 0, 2'd1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("v05_fetch_end",      0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v06_idle",           0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v07_contend",        1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v08_data_gnt",       1, 1, 1, 0, 0, 2'd2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("v09_data_ack",       1, 1, 1, 1, 0, 2'd2, 1, 1, 0, 0, 1, 0));
    vecs.push_back(mk("v10_data_end",       1, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v11_fetch_pending",  1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v12_fetch_gnt",      1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v13_fetch_ack",      1, 0, 0, 1, 0, 2'd1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("v14_fetch_end",      0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v15_idle_stray_ack", 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v16_data_req",       0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v17_ack_and_err",    0, 1, 0, 1, 1, 2'd2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("v18_data_end",       0, 0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("v19_idle",           0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      cycle(vecs[k].i_req, vecs[k].d_req, vecs[k].d_we, vecs[k].ack, vecs[k].err);
      chk_all(vecs[k].name, vecs[k].e_owner, vecs[k].e_cyc, vecs[k].e_we, vecs[k].e_iack,
              vecs[k].e_ierr, vecs[k].e_dack, vecs[k].e_derr, vecs[k].d_we);
    end

    // Reset while the data master waits on an ack; a late ack must be ignored.
    cycle(0, 1, 1, 0, 0);
    chk("rst.pre_idle_owner", 32'(owner), 32'd0);
    cycle(0, 1, 1, 0, 0);
    rst = 1'b1;
    chk("rst.gnt_owner", 32'(owner), 32'd2);
    chk("rst.gnt_cyc", 32'(s_bus.cyc), 32'd1);
    cycle(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk_all("rst.after", 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Same contention pattern twice: grants must run D, I, D, I.
    for (int rep = 0; rep < 2; rep++) begin
      cycle(1, 1, 0, 0, 0);
      chk($sformatf("alt%0d.idle_owner", rep), 32'(owner), 32'd0);
      cycle(1, 1, 0, 1, 0);
      chk($sformatf("alt%0d.first_owner", rep), 32'(owner), 32'd2);
      chk($sformatf("alt%0d.first_dack", rep), 32'(d_bus.ack), 32'd1);
      chk($sformatf("alt%0d.first_iack", rep), 32'(i_bus.ack), 32'd0);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk($sformatf("alt%0d.gap_owner", rep), 32'(owner), 32'd0);
      cycle(1, 0, 0, 1, 0);
      chk($sformatf("alt%0d.second_owner", rep), 32'(owner), 32'd1);
      chk($sformatf("alt%0d.second_iack", rep), 32'(i_bus.ack), 32'd1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end

    // Data granted last: round-robin hands contention to fetch, fixed priority to data.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    chk("prio.data_alone", 32'(owner), 32'd2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk("prio.contend_winner", 32'(owner), 32'(rr_owner));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Watchdog: no ack for TIMEOUT=4 strobe cycles -> err on the fifth granted cycle.
    cycle(0, 1, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      cycle(1, 1, 0, 0, 0);
      chk($sformatf("wd.g%0d_owner", g), 32'(owner), 32'd2);
      chk($sformatf("wd.g%0d_cyc", g), 32'(s_bus.cyc), 32'd1);
      chk($sformatf("wd.g%0d_derr", g), 32'(d_bus.err), 32'd0);
    end
    cycle(1, 1, 0, 0, 0);
    chk_all("wd.abort", 2'd2, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    chk_all("wd.idle", 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("wd.fetch_owner", 32'(owner), 32'd1);
    chk("wd.fetch_cyc", 32'(s_bus.cyc), 32'd1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
